// File: rtl/camera_pkg.sv
// Shared types and constants for the camera exposure/readout sequencer.
package camera_pkg;

    localparam int EXP_W       = 5;
    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        EXPOSE,
        R1_EN,
        R1_ADC,
        R1_OFF,
        R2_EN,
        R2_ADC,
        R2_OFF
    } state_t;

endpackage

// File: rtl/exp_time_reg.sv
// Saturating up/down exposure-time register; only moves while enabled.
module exp_time_reg #(
    parameter int W         = camera_pkg::EXP_W,
    parameter int MIN       = camera_pkg::EXP_MIN,
    parameter int MAX       = camera_pkg::EXP_MAX,
    parameter int RESET_VAL = camera_pkg::EXP_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= W'(RESET_VAL);
        end else if (en) begin
            // Both buttons together cancel out; each direction stops at its bound.
            if (inc && !dec && (value < W'(MAX))) begin
                value <= value + W'(1);
            end else if (dec && !inc && (value > W'(MIN))) begin
                value <= value - W'(1);
            end
        end
    end

endmodule

// File: rtl/re_control.sv
// Exposure and readout sequencer for the 2x2 pixel array: erase while idle,
// expose for exp_time cycles, then read row 1 and row 2 with one ADC strobe each.
module re_control #(
    parameter logic DANGLING_INPUT_CONSTANT = 1'bz,
    parameter int   EXP_MIN     = camera_pkg::EXP_MIN,
    parameter int   EXP_MAX     = camera_pkg::EXP_MAX,
    parameter int   EXP_DEFAULT = camera_pkg::EXP_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Init,
    input  logic Exp_increase,
    input  logic Exp_decrease,
    output logic Erase,
    output logic Expose,
    output logic NRE_1,
    output logic NRE_2,
    output logic ADC
);

    import camera_pkg::*;

    logic unused_dangling;
    assign unused_dangling = DANGLING_INPUT_CONSTANT;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t             state;
    state_t             state_next;
    logic [EXP_W-1:0]   exp_time;
    logic [EXP_W-1:0]   exp_cnt;
    logic               exp_en;

    // Buttons only count in IDLE and never in the same cycle a capture starts.
    assign exp_en = (state == IDLE) && !Init;

    exp_time_reg #(
        .W         (EXP_W),
        .MIN       (EXP_MIN),
        .MAX       (EXP_MAX),
        .RESET_VAL (EXP_DEFAULT)
    ) u_exp_time_reg (
        .clk   (Clk),
        .reset (Reset),
        .en    (exp_en),
        .inc   (Exp_increase),
        .dec   (Exp_decrease),
        .value (exp_time)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            exp_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && Init) begin
                exp_cnt <= exp_time;
            end else if (state == EXPOSE) begin
                exp_cnt <= exp_cnt - EXP_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Init) state_next = EXPOSE;
            // exp_cnt holds the remaining EXPOSE cycles including this one.
            EXPOSE:  if (exp_cnt <= EXP_W'(1)) state_next = R1_EN;
            R1_EN:   state_next = R1_ADC;
            R1_ADC:  state_next = R1_OFF;
            R1_OFF:  state_next = R2_EN;
            R2_EN:   state_next = R2_ADC;
            R2_ADC:  state_next = R2_OFF;
            R2_OFF:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Erase  = 1'b0;
        Expose = 1'b0;
        NRE_1  = 1'b1;
        NRE_2  = 1'b1;
        ADC    = 1'b0;
        case (state)
            IDLE:    Erase  = 1'b1;
            EXPOSE:  Expose = 1'b1;
            R1_EN:   NRE_1  = 1'b0;
            R1_ADC: begin
                NRE_1 = 1'b0;
                ADC   = 1'b1;
            end
            R2_EN:   NRE_2  = 1'b0;
            R2_ADC: begin
                NRE_2 = 1'b0;
                ADC   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_re_control.sv
// Bench for re_control: expected output vectors {Erase,Expose,NRE_1,NRE_2,ADC}
// are queued per clock from a timing model and compared on the falling edge.
module tb_re_control;

    localparam logic [4:0] V_IDLE   = 5'b10110;
    localparam logic [4:0] V_EXPOSE = 5'b01110;
    localparam logic [4:0] V_R1_EN  = 5'b00010;
    localparam logic [4:0] V_R1_ADC = 5'b00011;
    localparam logic [4:0] V_R1_OFF = 5'b00110;
    localparam logic [4:0] V_R2_EN  = 5'b00100;
    localparam logic [4:0] V_R2_ADC = 5'b00101;
    localparam logic [4:0] V_R2_OFF = 5'b00110;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic init = 1'b0;
    logic exp_increase = 1'b0;
    logic exp_decrease = 1'b0;
    logic erase, expose, nre_1, nre_2, adc;

    logic [4:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         model_exp = 15;
    string      phase = "start";

    re_control dut (
        .Clk          (clk),
        .Reset        (reset),
        .Init         (init),
        .Exp_increase (exp_increase),
        .Exp_decrease (exp_decrease),
        .Erase        (erase),
        .Expose       (expose),
        .NRE_1        (nre_1),
        .NRE_2        (nre_2),
        .ADC          (adc)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [%s] @%0t: got %0h expected %0h", tag, phase, $time, got, exp);
        end
    endtask

    // scoreboard: pop one expected vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_eq("outputs", {27'd0, erase, expose, nre_1, nre_2, adc}, {27'd0, exp_q.pop_front()});
        end
    end

    // driver tasks: inputs already set by the caller; push the vector due after the edge
    task automatic step(input logic [4:0] v);
        @(posedge clk);
        exp_q.push_back(v);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        init = 1'b0;
        exp_increase = 1'b0;
        exp_decrease = 1'b0;
        step(V_IDLE);
        step(V_IDLE);
        reset = 1'b0;
        model_exp = 15;
    endtask

    task automatic idle(input int n, input logic inc, input logic dec);
        init = 1'b0;
        exp_increase = inc;
        exp_decrease = dec;
        for (int i = 0; i < n; i++) begin
            if (inc && !dec && model_exp < 30) model_exp++;
            else if (dec && !inc && model_exp > 2) model_exp--;
            step(V_IDLE);
        end
        exp_increase = 1'b0;
        exp_decrease = 1'b0;
    endtask

    // Full capture from IDLE, ending with the first IDLE cycle pushed.
    task automatic capture(input logic hold_inc, input logic hold_init);
        init = 1'b1;
        exp_increase = hold_inc;
        step(V_EXPOSE);
        init = hold_init;
        for (int i = 1; i < model_exp; i++) step(V_EXPOSE);
        step(V_R1_EN);
        step(V_R1_ADC);
        step(V_R1_OFF);
        step(V_R2_EN);
        step(V_R2_ADC);
        step(V_R2_OFF);
        step(V_IDLE);
        init = 1'b0;
        exp_increase = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;

        phase = "reset_idle";
        do_reset();
        idle(3, 1'b0, 1'b0);

        phase = "default_capture";
        capture(1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);

        phase = "sat_max";
        idle(40, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        capture(1'b0, 1'b0);

        phase = "sat_min";
        idle(40, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);
        capture(1'b0, 1'b0);

        phase = "both_buttons";
        do_reset();
        idle(6, 1'b1, 1'b1);
        capture(1'b1, 1'b0);
        phase = "inc_during_expose";
        idle(1, 1'b0, 1'b0);
        capture(1'b0, 1'b0);

        phase = "step_changes";
        idle(3, 1'b0, 1'b1);
        idle(1, 1'b1, 1'b0);
        capture(1'b0, 1'b0);

        phase = "reset_mid_readout";
        idle(8, 1'b1, 1'b0);
        init = 1'b1;
        step(V_EXPOSE);
        init = 1'b0;
        for (int i = 1; i < model_exp; i++) step(V_EXPOSE);
        step(V_R1_EN);
        step(V_R1_ADC);
        step(V_R1_OFF);
        step(V_R2_EN);
        reset = 1'b1;
        step(V_IDLE);
        reset = 1'b0;
        model_exp = 15;
        step(V_IDLE);
        capture(1'b0, 1'b0);

        phase = "init_held";
        idle(2, 1'b0, 1'b0);
        capture(1'b0, 1'b1);
        capture(1'b0, 1'b1);
        capture(1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);

        phase = "drain";
        @(negedge clk);
        #1;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
